// File: rtl/mem_copy_engine_pkg.sv
// -----------------------------------------------------------------------------
// mem_copy_engine_pkg
// Shared definitions for the memory copy/fill engine: FSM state encoding,
// operation codes and the default port widths.
// -----------------------------------------------------------------------------
package mem_copy_engine_pkg;

   // Default widths of the 16x8 data-memory port and the length field
   localparam int ADDR_W_DFLT = 4;
   localparam int DATA_W_DFLT = 8;
   localparam int LEN_W_DFLT  = 5;

   // Operation codes, captured together with start
   localparam logic OP_COPY = 1'b0;
   localparam logic OP_FILL = 1'b1;

   // Engine FSM states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_READ  = 2'b01,
      ST_WRITE = 2'b10,
      ST_DONE  = 2'b11
   } state_e;

endpackage : mem_copy_engine_pkg

// File: rtl/mem_copy_engine.sv
// -----------------------------------------------------------------------------
// mem_copy_engine
// Bus master for the data memory. On a start pulse it either copies len bytes
// from src to dst (one READ cycle followed by one WRITE cycle per byte) or
// fills len bytes at dst with fill_val (one WRITE cycle per byte). Addresses
// wrap modulo 2^ADDR_W. The mod-256 sum of every byte written is reported on
// checksum, which holds until the next accepted start.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start, op       request pulse (sampled in IDLE only), 0 = COPY / 1 = FILL
//   src, dst, len   first source / destination address, byte count
//   fill_val        constant written in FILL mode
//   busy, done      engine owns the memory port / one-cycle completion pulse
//   checksum        sum of all bytes written, mod 2^DATA_W
//   mem_en, mem_we, mem_addr, mem_din, mem_dout   data-memory port
//                   (mem_dout is combinational from mem_addr)
// -----------------------------------------------------------------------------
module mem_copy_engine
   import mem_copy_engine_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DFLT,
   parameter int DATA_W = DATA_W_DFLT,
   parameter int LEN_W  = LEN_W_DFLT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              op,
   input  logic [ADDR_W-1:0] src,
   input  logic [ADDR_W-1:0] dst,
   input  logic [LEN_W-1:0]  len,
   input  logic [DATA_W-1:0] fill_val,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] checksum,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout
);

   state_e              state_q,    state_d;
   logic                op_q,       op_d;
   logic [ADDR_W-1:0]   src_ptr_q,  src_ptr_d;
   logic [ADDR_W-1:0]   dst_ptr_q,  dst_ptr_d;
   logic [LEN_W-1:0]    remain_q,   remain_d;
   logic [DATA_W-1:0]   fill_q,     fill_d;
   logic [DATA_W-1:0]   data_q,     data_d;
   logic [DATA_W-1:0]   checksum_q, checksum_d;

   // Byte presented on the write port: latched read data or the fill constant
   logic [DATA_W-1:0]   wr_data_s;

   // Write-data select, depends only on registered operands
   always_comb begin
      if (op_q == OP_FILL) begin
         wr_data_s = fill_q;
      end else begin
         wr_data_s = data_q;
      end
   end

   // Next-state and datapath register update
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      src_ptr_d  = src_ptr_q;
      dst_ptr_d  = dst_ptr_q;
      remain_d   = remain_q;
      fill_d     = fill_q;
      data_d     = data_q;
      checksum_d = checksum_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               op_d       = op;
               src_ptr_d  = src;
               dst_ptr_d  = dst;
               remain_d   = len;
               fill_d     = fill_val;
               checksum_d = {DATA_W{1'b0}};
               if (len == {LEN_W{1'b0}}) begin
                  state_d = ST_DONE;
               end else if (op == OP_FILL) begin
                  state_d = ST_WRITE;
               end else begin
                  state_d = ST_READ;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_READ: begin
            data_d  = mem_dout;
            state_d = ST_WRITE;
         end

         ST_WRITE: begin
            checksum_d = checksum_q + wr_data_s;
            // Both pointers advance together; they wrap naturally at 2^ADDR_W
            src_ptr_d  = src_ptr_q + ADDR_W'(1);
            dst_ptr_d  = dst_ptr_q + ADDR_W'(1);
            remain_d   = remain_q - LEN_W'(1);
            if (remain_q == LEN_W'(1)) begin
               state_d = ST_DONE;
            end else if (op_q == OP_FILL) begin
               state_d = ST_WRITE;
            end else begin
               state_d = ST_READ;
            end
         end

         ST_DONE: begin
            // start is deliberately not sampled here
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         op_q       <= OP_COPY;
         src_ptr_q  <= {ADDR_W{1'b0}};
         dst_ptr_q  <= {ADDR_W{1'b0}};
         remain_q   <= {LEN_W{1'b0}};
         fill_q     <= {DATA_W{1'b0}};
         data_q     <= {DATA_W{1'b0}};
         checksum_q <= {DATA_W{1'b0}};
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         src_ptr_q  <= src_ptr_d;
         dst_ptr_q  <= dst_ptr_d;
         remain_q   <= remain_d;
         fill_q     <= fill_d;
         data_q     <= data_d;
         checksum_q <= checksum_d;
      end
   end

   // Moore output decode from registered state and pointers only
   always_comb begin
      busy     = 1'b0;
      done     = 1'b0;
      mem_en   = 1'b0;
      mem_we   = 1'b0;
      mem_addr = {ADDR_W{1'b0}};
      mem_din  = {DATA_W{1'b0}};
      case (state_q)
         ST_READ: begin
            busy     = 1'b1;
            mem_en   = 1'b1;
            mem_addr = src_ptr_q;
         end
         ST_WRITE: begin
            busy     = 1'b1;
            mem_en   = 1'b1;
            mem_we   = 1'b1;
            mem_addr = dst_ptr_q;
            mem_din  = wr_data_s;
         end
         ST_DONE: begin
            done = 1'b1;
         end
         ST_IDLE: begin
            done = 1'b0;
         end
         default: begin
            done = 1'b0;
         end
      endcase
   end

   assign checksum = checksum_q;

endmodule : mem_copy_engine

// File: tb/tb_mem_copy_engine.sv
// -----------------------------------------------------------------------------
// tb_mem_copy_engine
// Self-checking bench for mem_copy_engine. A 16x8 memory with combinational
// read acts as responder. Expected memory contents and checksums come from a
// byte-by-byte model of the copy/fill rules; expected busy/done timing comes
// from the cycle counts of each operation.
// -----------------------------------------------------------------------------
module tb_mem_copy_engine;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       op;
   logic [3:0] src;
   logic [3:0] dst;
   logic [4:0] len;
   logic [7:0] fill_val;
   logic       busy;
   logic       done;
   logic [7:0] checksum;
   logic       mem_en;
   logic       mem_we;
   logic [3:0] mem_addr;
   logic [7:0] mem_din;
   logic [7:0] mem_dout;

   // Responder memory plus a bench-side preload port
   logic [7:0] mem     [16];
   logic [7:0] ref_mem [16];
   logic       pl_we;
   logic [3:0] pl_addr;
   logic [7:0] pl_data;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_copy_engine dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .op       (op),
      .src      (src),
      .dst      (dst),
      .len      (len),
      .fill_val (fill_val),
      .busy     (busy),
      .done     (done),
      .checksum (checksum),
      .mem_en   (mem_en),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_din  (mem_din),
      .mem_dout (mem_dout)
   );

   assign mem_dout = mem[mem_addr];

   // Memory write port: bench preload has priority over the engine
   always @(posedge clk) begin
      if (pl_we) begin
         mem[pl_addr] <= pl_data;
      end else if (mem_en && mem_we) begin
         mem[mem_addr] <= mem_din;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [3:0] a, input logic [7:0] v);
      @(negedge clk);
      pl_we   = 1'b1;
      pl_addr = a;
      pl_data = v;
      ref_mem[a] = v;
      @(posedge clk);
      #1;
      pl_we = 1'b0;
   endtask

   task automatic check_mem(input string tag);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("%s_mem[%0d]", tag, i), {24'd0, mem[i]}, {24'd0, ref_mem[i]});
      end
   endtask

   // Reference: byte i is read from src+i (after earlier writes) and written to dst+i
   task automatic model(input logic o, input logic [3:0] s, input logic [3:0] d,
                        input int n, input logic [7:0] f, output logic [7:0] sum);
      logic [7:0] v;
      sum = 8'd0;
      for (int i = 0; i < n; i++) begin
         v = (o == 1'b1) ? f : ref_mem[(s + i) % 16];
         ref_mem[(d + i) % 16] = v;
         sum = 8'((int'(sum) + int'(v)) % 256);
      end
   endtask

   task automatic run_xfer(input string tag, input logic o, input logic [3:0] s,
                           input logic [3:0] d, input logic [4:0] n,
                           input logic [7:0] f, input int glitch_at);
      logic [7:0] exp_sum;
      int         b;
      model(o, s, d, int'(n), f, exp_sum);
      b = (n == 5'd0) ? 0 : ((o == 1'b1) ? int'(n) : 2 * int'(n));
      @(negedge clk);
      start = 1'b1; op = o; src = s; dst = d; len = n; fill_val = f;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int c = 1; c <= b + 1; c++) begin
         @(negedge clk);
         check($sformatf("%s_busy_c%0d", tag, c), {31'd0, busy}, {31'd0, (c <= b)});
         check($sformatf("%s_done_c%0d", tag, c), {31'd0, done}, {31'd0, (c == b + 1)});
         check($sformatf("%s_en_c%0d", tag, c), {31'd0, mem_en}, {31'd0, (c <= b)});
         if (c == b + 1) begin
            check($sformatf("%s_checksum", tag), {24'd0, checksum}, {24'd0, exp_sum});
         end
         if (c == glitch_at) begin
            start = 1'b1; src = s + 4'd5; len = 5'd1; op = ~o; fill_val = ~f;
         end else begin
            start = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      check($sformatf("%s_idle_busy", tag), {31'd0, busy}, 32'd0);
      check($sformatf("%s_idle_done", tag), {31'd0, done}, 32'd0);
      check($sformatf("%s_hold_checksum", tag), {24'd0, checksum}, {24'd0, exp_sum});
      check_mem(tag);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; op = 1'b0; src = 4'd0; dst = 4'd0;
      len = 5'd0; fill_val = 8'd0; pl_we = 1'b0; pl_addr = 4'd0; pl_data = 8'd0;
      #1;
      check("rst_busy",     {31'd0, busy},     32'd0);
      check("rst_done",     {31'd0, done},     32'd0);
      check("rst_checksum", {24'd0, checksum}, 32'd0);
      check("rst_mem_en",   {31'd0, mem_en},   32'd0);
      check("rst_mem_we",   {31'd0, mem_we},   32'd0);
      check("rst_mem_addr", {28'd0, mem_addr}, 32'd0);
      check("rst_mem_din",  {24'd0, mem_din},  32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++) preload(4'(i), 8'd0);

      // Basic copy
      preload(4'd2, 8'h11); preload(4'd3, 8'h22); preload(4'd4, 8'h33);
      run_xfer("copy3", 1'b0, 4'd2, 4'd9, 5'd3, 8'h00, 0);
      check("copy3_sum_const", {24'd0, checksum}, 32'h66);

      // Fill across the address wrap
      run_xfer("fill_wrap", 1'b1, 4'd14, 4'd0, 5'd4, 8'hA5, 0);
      check("fill_wrap_sum_const", {24'd0, checksum}, 32'h94);

      // Zero-length requests
      run_xfer("copy0", 1'b0, 4'd5, 4'd6, 5'd0, 8'h00, 0);
      run_xfer("fill0", 1'b1, 4'd5, 4'd6, 5'd0, 8'h5A, 0);

      // Forward overlap propagation
      preload(4'd0, 8'h7E);
      run_xfer("overlap", 1'b0, 4'd0, 4'd1, 5'd3, 8'h00, 0);
      check("overlap_sum_const", {24'd0, checksum}, 32'h7A);

      // start pulses during a transfer and during DONE are ignored
      run_xfer("glitch_mid", 1'b0, 4'd3, 4'd12, 5'd5, 8'h00, 4);
      run_xfer("glitch_done", 1'b1, 4'd7, 4'd8, 5'd3, 8'h3C, 4);

      // Reset in cycle 3 of a COPY len=4: only the first byte is written
      preload(4'd4, 8'hC1); preload(4'd5, 8'hC2); preload(4'd6, 8'hC3); preload(4'd7, 8'hC4);
      preload(4'd8, 8'h00); preload(4'd9, 8'h00); preload(4'd10, 8'h00); preload(4'd11, 8'h00);
      ref_mem[8] = ref_mem[4];
      @(negedge clk);
      start = 1'b1; op = 1'b0; src = 4'd4; dst = 4'd8; len = 5'd4;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("arst_busy",     {31'd0, busy},     32'd0);
      check("arst_done",     {31'd0, done},     32'd0);
      check("arst_checksum", {24'd0, checksum}, 32'd0);
      check("arst_mem_en",   {31'd0, mem_en},   32'd0);
      check("arst_mem_we",   {31'd0, mem_we},   32'd0);
      check("arst_mem_addr", {28'd0, mem_addr}, 32'd0);
      check("arst_mem_din",  {24'd0, mem_din},  32'd0);
      repeat (2) @(negedge clk);
      check("arst_hold_busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("arst_no_resume", {31'd0, busy}, 32'd0);
      check_mem("arst");
      run_xfer("after_rst", 1'b0, 4'd4, 4'd12, 5'd4, 8'h00, 0);

      // Randomised transfers
      for (int t = 0; t < 12; t++) begin
         for (int i = 0; i < 16; i++) preload(4'(i), 8'($urandom_range(0, 255)));
         run_xfer($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_mem_copy_engine

// File: doc/mem_copy_engine.md
# mem_copy_engine

Bus-master block that drives the 16×8 data memory port (en/we/addr/din/dout) to move data without processor involvement. On a start pulse it either copies a run of bytes from a source address to a destination address, or fills a run with a constant byte. It also returns a mod-256 checksum of the bytes written. It sits beside the processor datapath, and a top-level mux grants it the data-memory port while `busy` is high.

## Interface
- `ADDR_W`, 4, data-memory address width
- `DATA_W`, 8, data-memory word width
- `LEN_W`, 5, transfer-length width (0–31 bytes)
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request pulse, sampled only in IDLE
- `op`  in  1  0 = COPY, 1 = FILL; captured with `start`
- `src`  in  ADDR_W  first source address (COPY only)
- `dst`  in  ADDR_W  first destination address
- `len`  in  LEN_W  number of bytes to transfer
- `fill_val`  in  DATA_W  constant written in FILL mode
- `busy`  out  1  high while the engine owns the memory port
- `done`  out  1  one-cycle completion pulse
- `checksum`  out  DATA_W  sum of all bytes written, mod 256
- `mem_en`  out  1  memory enable
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_din`  out  DATA_W  memory write data
- `mem_dout`  in  DATA_W  memory read data; combinational, valid in the same cycle as `mem_addr`

## Operation
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - On `start`=1, latch `op`, `src`, `dst`, `len`, `fill_val` into registers and clear `checksum`.
  - If `len`=0, go to DONE.
  - Otherwise go to READ for COPY, or WRITE for FILL.
- READ (COPY only):
  - Drive `mem_en`=1, `mem_we`=0, `mem_addr`=src_ptr.
  - At the clock edge, latch `mem_dout` into data_reg and go to WRITE.
- WRITE:
  - Drive `mem_en`=1, `mem_we`=1, `mem_addr`=dst_ptr, `mem_din`=data_reg for COPY or fill_val for FILL.
  - At the clock edge:
    - checksum += `mem_din` (wraps mod 256).
    - dst_ptr += 1 and src_ptr += 1, both wrapping mod 2^ADDR_W (15 → 0).
    - remaining −= 1.
  - If remaining was 1, go to DONE. Otherwise go to READ (COPY) or stay in WRITE (FILL).
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- Memory-port outputs are all 0 in IDLE and DONE.
- `busy`=1 in READ and WRITE only.
- `start` is ignored outside IDLE, including in the DONE cycle.
- Copies run forward only. With overlapping regions and dst>src, already-written bytes are re-read, which is the required behaviour; there is no overlap correction.
- `len` > 16 wraps the addresses and revisits locations. This is legal.
- `checksum` holds its value after DONE until the next accepted `start`.
- `rst_n` low, at any time including mid-transfer:
  - State goes to IDLE immediately.
  - All outputs go to 0: `busy`, `done`, `checksum`, `mem_en`, `mem_we`, `mem_addr`, `mem_din`.
  - An aborted transfer is not resumed.

## Timing
- The edge that accepts `start` is edge 0.
- COPY with len=N: READ/WRITE alternate for 2N cycles. `busy` is high for cycles 1..2N, and `done` is high in cycle 2N+1.
- FILL with len=N: WRITE for N cycles. `busy` is high for cycles 1..N, and `done` is high in cycle N+1.
- len=0: `done` is high in cycle 1 and `busy` never rises.
- The earliest next `start` is accepted at the edge ending the DONE cycle+1, i.e. first IDLE cycle.
- Memory-port outputs are Moore-decoded from registered state and pointers only. There is no combinational path from `mem_dout` to any output.

## Structure
- The shared package holds:
  - State encoding: IDLE=2'b00, READ=2'b01, WRITE=2'b10, DONE=2'b11.
  - Op codes OP_COPY=1'b0 and OP_FILL=1'b1.
  - Default widths ADDR_W, DATA_W, LEN_W.
- Single module with no sub-module. Pointer increment and length counter are inline registers.
- The bench instantiates the existing data memory as the responder.

## Test plan
- Preload mem[2..4]=8'h11,8'h22,8'h33; COPY src=2 dst=9 len=3 → mem[9..11]=11,22,33; `done` at cycle 7; checksum=8'h66; `busy` high cycles 1–6.
- FILL dst=14 len=4 fill_val=8'hA5 → mem[14],mem[15],mem[0],mem[1]=A5 (address wrap); `done` at cycle 5; checksum=8'h94.
- COPY or FILL with len=0 → `done` in cycle 1; no `mem_en` ever; checksum=0.
- Preload mem[0]=8'h7E; COPY src=0 dst=1 len=3 → mem[1..3]=7E (forward overlap propagation); checksum=8'h7A.
- `start` pulsed again during a transfer, with changed `src`/`len` → ignored; first transfer completes unchanged.
- Drop `rst_n` in cycle 3 of a COPY len=4 → all outputs 0 immediately; only the bytes written before reset are changed; a new `start` after release runs normally.
